// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: owns the IF/ID and ID/EX pipeline registers and
// arbitrates freeze, flush and load-use stall, with saturating event counters.
module decode_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      imm_in,
  input  logic             mem_busy,
  input  logic             ex_branch_taken,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             if_stall,
  output logic             idex_valid,
  output logic [31:0]      idex_pc,
  output logic [31:0]      idex_imm,
  output logic [4:0]       idex_rs1,
  output logic [4:0]       idex_rs2,
  output logic [4:0]       idex_rd,
  output logic             idex_memread,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       ctrl_state
);

  typedef enum logic [1:0] {
    ACT_RUN      = 2'd0,
    ACT_LU_STALL = 2'd1,
    ACT_FLUSH    = 2'd2,
    ACT_FREEZE   = 2'd3
  } action_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       rs1_used;
  logic       rs2_used;
  logic       is_load;
  logic       hazard;
  action_e    action;
  action_e    state_q;

  assign opcode   = id_instr[6:0];
  assign rs1      = id_instr[19:15];
  assign rs2      = id_instr[24:20];
  assign rd       = id_instr[11:7];
  assign rs1_used = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign rs2_used = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  assign is_load  = (opcode == OPC_LOAD);

  // x0 never carries a loaded value, so a load targeting it cannot stall anyone.
  assign hazard = id_valid && idex_valid && idex_memread && (idex_rd != 5'd0) &&
                  ((rs1_used && (idex_rd == rs1)) || (rs2_used && (idex_rd == rs2)));

  // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    action = ACT_RUN;
    if (mem_busy)             action = ACT_FREEZE;
    else if (ex_branch_taken) action = ACT_FLUSH;
    else if (hazard)          action = ACT_LU_STALL;
  end

  assign if_stall   = (action == ACT_FREEZE) || (action == ACT_LU_STALL);
  assign ctrl_state = state_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid     <= 1'b0;
      id_instr     <= '0;
      id_pc        <= '0;
      idex_valid   <= 1'b0;
      idex_pc      <= '0;
      idex_imm     <= '0;
      idex_rs1     <= '0;
      idex_rs2     <= '0;
      idex_rd      <= '0;
      idex_memread <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      state_q      <= ACT_RUN;
    end else begin
      state_q <= action;
      unique case (action)
        ACT_RUN: begin
          id_valid     <= if_valid;
          id_instr     <= if_instr;
          id_pc        <= if_pc;
          idex_valid   <= id_valid;
          idex_pc      <= id_pc;
          idex_imm     <= imm_in;
          idex_rs1     <= rs1;
          idex_rs2     <= rs2;
          idex_rd      <= rd;
          idex_memread <= is_load;
        end
        ACT_LU_STALL: begin
          // The bubble drops idex_memread, which is what ends the stall next cycle.
          idex_valid   <= 1'b0;
          idex_memread <= 1'b0;
          if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
        end
        ACT_FLUSH: begin
          id_valid     <= 1'b0;
          idex_valid   <= 1'b0;
          idex_memread <= 1'b0;
          if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
        end
        ACT_FREEZE: begin
          if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboard bench for decode_hazard_ctrl: a spec-level model pushes the expected
// register image each cycle; it is popped and compared one edge later.
module tb_decode_hazard_ctrl;

  localparam logic [31:0] LW5    = 32'h00012283;  // lw   x5,0(x2)
  localparam logic [31:0] ADD_HZ = 32'h00128333;  // add  x6,x5,x1
  localparam logic [31:0] LW0    = 32'h00012003;  // lw   x0,0(x2)
  localparam logic [31:0] ADD_X0 = 32'h00100333;  // add  x6,x0,x1
  localparam logic [31:0] ADDI   = 32'h80000093;  // addi x1,x0,-2048
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] LUI5   = 32'h000283b7;  // lui with x5 in the rs1 field
  localparam logic [31:0] SW5    = 32'h00512023;  // sw   x5,0(x2)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic [31:0] imm_in = '0;
  logic        mem_busy = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic        id_valid, if_stall, idex_valid, idex_memread;
  logic [31:0] id_instr, id_pc, idex_pc, idex_imm;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  ctrl_state;

  decode_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .imm_in(imm_in), .mem_busy(mem_busy), .ex_branch_taken(ex_branch_taken),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .if_stall(if_stall),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_imm(idex_imm),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id_valid;
    logic [31:0] id_instr, id_pc;
    bit          id_known;
    logic        idex_valid;
    logic [31:0] idex_pc, idex_imm;
    logic [4:0]  rs1, rs2, rd;
    logic        memread;
    bit          idex_known;
    bit          mr_known;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  state;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t reset_rec();
    exp_t r;
    r = '{default: '0};
    r.id_known = 1'b1;
    r.idex_known = 1'b1;
    r.mr_known = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic compare(input exp_t e);
    check("id_valid", id_valid, e.id_valid);
    if (e.id_known) begin
      check("id_instr", id_instr, e.id_instr);
      check("id_pc", id_pc, e.id_pc);
    end
    check("idex_valid", idex_valid, e.idex_valid);
    if (e.idex_known) begin
      check("idex_pc", idex_pc, e.idex_pc);
      check("idex_imm", idex_imm, e.idex_imm);
      check("idex_rs1", idex_rs1, e.rs1);
      check("idex_rs2", idex_rs2, e.rs2);
      check("idex_rd", idex_rd, e.rd);
    end
    if (e.mr_known) check("idex_memread", idex_memread, e.memread);
    check("stall_cnt", stall_cnt, e.stall_cnt);
    check("flush_cnt", flush_cnt, e.flush_cnt);
    check("ctrl_state", ctrl_state, e.state);
  endtask

  // Drive one cycle of inputs, predict from the model, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] imm, input logic busy, input logic br, input bit chk);
    exp_t nx;
    logic [6:0] op;
    logic u1, u2, hz;
    logic [1:0] act;
    rst = r; if_valid = v; if_instr = ins; if_pc = pc; imm_in = imm;
    mem_busy = busy; ex_branch_taken = br;
    #1;
    op = m.id_instr[6:0];
    u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    hz = m.id_valid && m.idex_valid && m.memread && (m.rd != 5'd0) &&
         ((u1 && m.rd == m.id_instr[19:15]) || (u2 && m.rd == m.id_instr[24:20]));
    act = busy ? 2'd3 : br ? 2'd2 : hz ? 2'd1 : 2'd0;
    if (chk && !r) check("if_stall", if_stall, (act == 2'd3 || act == 2'd1));
    nx = m;
    if (r) nx = reset_rec();
    else begin
      case (act)
        2'd0: begin
          nx.id_valid = v; nx.id_instr = ins; nx.id_pc = pc; nx.id_known = 1'b1;
          nx.idex_valid = m.id_valid; nx.idex_pc = m.id_pc; nx.idex_imm = imm;
          nx.rs1 = m.id_instr[19:15]; nx.rs2 = m.id_instr[24:20]; nx.rd = m.id_instr[11:7];
          nx.memread = (op == 7'b0000011);
          nx.idex_known = m.id_known; nx.mr_known = m.id_known;
        end
        2'd1: begin
          nx.idex_valid = 1'b0; nx.memread = 1'b0; nx.mr_known = 1'b1; nx.idex_known = 1'b0;
          nx.stall_cnt = sat_inc(m.stall_cnt);
        end
        2'd2: begin
          nx.id_valid = 1'b0; nx.idex_valid = 1'b0; nx.memread = 1'b0;
          nx.id_known = 1'b0; nx.idex_known = 1'b0; nx.mr_known = 1'b0;
          nx.flush_cnt = sat_inc(m.flush_cnt);
        end
        default: nx.stall_cnt = sat_inc(m.stall_cnt);
      endcase
      nx.state = act;
    end
    m = nx;
    if (chk) sb.push_back(nx);
    @(posedge clk);
    #1;
    if (chk && sb.size() > 0) compare(sb.pop_front());
  endtask

  task automatic run(input logic [31:0] ins, input logic [31:0] pc);
    step(1'b0, 1'b1, ins, pc, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [15:0] s0;
    logic [31:0] pool [8];
    pool[0] = LW5; pool[1] = ADD_HZ; pool[2] = LW0; pool[3] = ADD_X0;
    pool[4] = ADDI; pool[5] = NOP; pool[6] = LUI5; pool[7] = SW5;
    m = reset_rec();

    // Reset, then if_stall must be low on the first free cycle.
    step(1'b1, 1'b1, LW5, 32'h4, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0; #1;
    check("rst_if_stall", if_stall, 1'b0);

    // lw x0 followed by a reader of x0: no stall.
    run(LW0, 32'h200);
    run(ADD_X0, 32'h204);
    run(NOP, 32'h208);
    check("x0_stall_cnt", stall_cnt, 16'd0);
    check("x0_ctrl", ctrl_state, 2'd0);

    // Load-use: exactly one bubble, then add captured with rs1 = x5.
    run(LW5, 32'h100);
    run(ADD_HZ, 32'h104);
    run(NOP, 32'h108);
    check("lu_idex_valid", idex_valid, 1'b0);
    check("lu_stall_cnt", stall_cnt, 16'd1);
    check("lu_ctrl", ctrl_state, 2'd1);
    check("lu_one_cycle", if_stall, 1'b0);
    run(NOP, 32'h108);
    check("lu_rs1", idex_rs1, 5'd5);
    check("lu_capture", idex_valid, 1'b1);

    // Branch redirect coincident with a load-use hazard: flush wins.
    run(LW5, 32'h120);
    run(ADD_HZ, 32'h124);
    s0 = m.stall_cnt;
    step(1'b0, 1'b1, NOP, 32'h128, 32'h0, 1'b0, 1'b1, 1'b1);
    check("fl_id_valid", id_valid, 1'b0);
    check("fl_idex_valid", idex_valid, 1'b0);
    check("fl_flush_cnt", flush_cnt, 16'd1);
    check("fl_stall_cnt", stall_cnt, s0);

    // Freeze for three cycles with a pending redirect, then flush.
    run(NOP, 32'h300);
    run(ADDI, 32'h304);
    s0 = m.stall_cnt;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, NOP, 32'h308, 32'h0, 1'b1, 1'b1, 1'b1);
    check("fz_stall_cnt", stall_cnt, s0 + 16'd3);
    check("fz_id_pc", id_pc, 32'h304);
    check("fz_idex_pc", idex_pc, 32'h300);
    step(1'b0, 1'b1, NOP, 32'h308, 32'h0, 1'b0, 1'b1, 1'b1);
    check("fz_then_flush", ctrl_state, 2'd2);

    // Immediate passthrough.
    run(ADDI, 32'h400);
    step(1'b0, 1'b1, NOP, 32'h404, 32'hFFFFF800, 1'b0, 1'b0, 1'b1);
    check("imm_value", idex_imm, 32'hFFFFF800);
    check("imm_memread", idex_memread, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++)
      step(1'b0, ($urandom_range(7) != 0), pool[$urandom_range(7)], 32'h1000 + 32'(i * 4),
           $urandom, ($urandom_range(7) == 0), ($urandom_range(9) == 0), 1'b1);

    // Drive the stall counter into saturation, then reset mid-freeze.
    for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, NOP, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, NOP, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("sat_stall_cnt", stall_cnt, 16'hFFFF);
    step(1'b1, 1'b1, NOP, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_flush_cnt", flush_cnt, 16'd0);
    check("rst_ctrl", ctrl_state, 2'd0);
    check("rst_idex_pc", idex_pc, 32'h0);
    run(NOP, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_hazard_ctrl.md
DECODE_HAZARD_CTRL -- requirements
Module: decode_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port if_valid  in  1  fetch stage presents a valid instruction.
REQ-005 SHALL have ports if_instr  in  32 and if_pc  in  32  fetched instruction and its PC.
REQ-006 SHALL have port imm_in  in  32  sign-extended immediate computed externally from id_instr.
REQ-007 SHALL have port mem_busy  in  1  memory stage not ready; freezes the front end.
REQ-008 SHALL have port ex_branch_taken  in  1  EX stage resolved taken branch/jump (redirect).
REQ-009 SHALL have ports id_valid  out  1, id_instr  out  32 and id_pc  out  32  IF/ID register contents.
REQ-010 SHALL have port if_stall  out  1  hold the PC and fetch outputs this cycle.
REQ-011 SHALL have ports idex_valid  out  1, idex_pc  out  32, idex_imm  out  32, idex_rs1/idex_rs2/idex_rd  out  5 each, and idex_memread  out  1  ID/EX register contents.
REQ-012 SHALL have ports stall_cnt  out  CNT_W and flush_cnt  out  CNT_W  saturating event counters.
REQ-013 SHALL have port ctrl_state  out  2  registered action of the previous cycle: 0 RUN, 1 LU_STALL, 2 FLUSH, 3 FREEZE.

Function
REQ-014 SHALL decode from id_instr: opcode [6:0], rs1 [19:15], rs2 [24:20], rd [11:7].
REQ-015 SHALL treat rs1 as used for all opcodes except 0110111 (lui), 0010111 (auipc) and 1101111 (jal).
REQ-016 SHALL treat rs2 as used only for opcodes 0110011, 0100011 and 1100011.
REQ-017 SHALL drive idex_memread = 1 on capture iff the opcode is 0000011.
REQ-018 SHALL flag a load-use hazard when id_valid & idex_valid & idex_memread & idex_rd != 0 and idex_rd equals a used rs1 or rs2.
REQ-019 SHALL select exactly one action per cycle, with priority FREEZE (mem_busy) > FLUSH (ex_branch_taken) > LU_STALL (hazard) > RUN.
REQ-020 SHALL, in FREEZE, hold the IF/ID and ID/EX registers unchanged, assert if_stall, and ignore ex_branch_taken (EX holds it until mem_busy drops).
REQ-021 SHALL, in FLUSH, clear id_valid and idex_valid on the next edge, deassert if_stall, and leave the payload fields don't-care.
REQ-022 SHALL, in LU_STALL, hold IF/ID, assert if_stall, and load ID/EX with a bubble (idex_valid = 0, idex_memread = 0).
REQ-023 SHALL, in RUN, load IF/ID from if_valid/if_instr/if_pc, and load ID/EX from id_valid, id_pc, imm_in, decoded fields and memread.
REQ-024 SHALL compute if_stall combinationally in the same cycle as the action decision, with zero latency.
REQ-025 SHALL guarantee that a load-use stall lasts exactly one cycle, because the bubble clears the hazard condition.
REQ-026 SHALL increment stall_cnt by 1 for each LU_STALL or FREEZE cycle and flush_cnt by 1 for each FLUSH cycle, saturating at all-ones with no wrap.
REQ-027 SHALL register ctrl_state with the action code at each edge.
REQ-028 SHALL load an instruction with if_valid = 0 as a bubble (id_valid = 0) and never let it cause a hazard.

Reset
REQ-029 SHALL, when rst is high at an edge, clear id_valid, idex_valid, idex_memread, all payload registers, both counters and ctrl_state (0 = RUN).
REQ-030 SHALL let rst override every other input, including mid-stall and mid-freeze.
REQ-031 SHALL hold if_stall at 0 on the cycle after reset while mem_busy = 0.

Verification
REQ-032 SHALL cover the load-use case: lw x5 in ID/EX, then add x6,x5,x1 (0x00128333) in ID -> if_stall = 1 for one cycle, idex_valid = 0, stall_cnt = 1; the next cycle captures add with idex_rs1 = 5.
REQ-033 SHALL cover the x0 exemption: lw x0 followed by add using x0 -> no stall, and stall_cnt stays 0.
REQ-034 SHALL cover simultaneous events: ex_branch_taken = 1 with a load-use hazard present -> FLUSH wins, id_valid = idex_valid = 0, flush_cnt += 1, and stall_cnt is unchanged.
REQ-035 SHALL cover freeze: mem_busy = 1 for 3 cycles with ex_branch_taken = 1 -> registers held, stall_cnt += 3, then FLUSH on the first cycle after mem_busy falls.
REQ-036 SHALL cover immediate passthrough: addi with imm_in = 0xFFFFF800 in RUN -> idex_imm = 0xFFFFF800 and idex_memread = 0 after one edge.
REQ-037 SHALL cover saturation and reset: force stall_cnt to 0xFFFF and stall again -> it stays 0xFFFF; then assert rst mid-stall -> all outputs 0 on the next edge.
